// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// operand-forwarding select codes seen by the EXE-stage operand muxes.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        RUN      = 3'd1,
        MEM_WAIT = 3'd2,
        HALT     = 3'd3,
        STEP     = 3'd4
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF     = 2'b00;  // register file read data
    localparam fwd_sel_t FWD_WB     = 2'b01;  // regw_data_wb
    localparam fwd_sel_t FWD_MEMDIN = 2'b10;  // mem_din (load in EXE)
    localparam fwd_sel_t FWD_ALU    = 2'b11;  // alu_out_mem

    localparam int NUM_STAGES = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard information from the datapath and the control /
// counter outputs back to it. The datapath side is the master, the
// controller is the slave.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             debug_en;
    logic             debug_step;
    logic             is_branch_id;
    logic             is_branch_exe;
    logic             is_branch_mem;
    logic [4:0]       addr_rs_id;
    logic [4:0]       addr_rt_id;
    logic [4:0]       regw_addr_exe;
    logic             wb_wen_exe;
    logic             mem_ren_exe;
    logic [4:0]       regw_addr_mem;
    logic             wb_wen_mem;
    logic             mem_ren_mem;
    logic             mem_wen_mem;
    logic             mem_ack;

    logic [1:0]       exe_fwd_a_ctrl;
    logic [1:0]       exe_fwd_b_ctrl;
    logic             if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic             if_en, id_en, exe_en, mem_en, wb_en;
    logic [CNT_W-1:0] cnt_cycle;
    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;
    logic             halted;

    modport master (
        output debug_en, debug_step, is_branch_id, is_branch_exe, is_branch_mem,
               addr_rs_id, addr_rt_id, regw_addr_exe, wb_wen_exe, mem_ren_exe,
               regw_addr_mem, wb_wen_mem, mem_ren_mem, mem_wen_mem, mem_ack,
        input  exe_fwd_a_ctrl, exe_fwd_b_ctrl,
               if_rst, id_rst, exe_rst, mem_rst, wb_rst,
               if_en, id_en, exe_en, mem_en, wb_en,
               cnt_cycle, cnt_stall, cnt_flush, halted
    );

    modport slave (
        input  debug_en, debug_step, is_branch_id, is_branch_exe, is_branch_mem,
               addr_rs_id, addr_rt_id, regw_addr_exe, wb_wen_exe, mem_ren_exe,
               regw_addr_mem, wb_wen_mem, mem_ren_mem, mem_wen_mem, mem_ack,
        output exe_fwd_a_ctrl, exe_fwd_b_ctrl,
               if_rst, id_rst, exe_rst, mem_rst, wb_rst,
               if_en, id_en, exe_en, mem_en, wb_en,
               cnt_cycle, cnt_stall, cnt_flush, halted
    );

endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one source operand of the instruction in ID.
// The nearer producer (EXE) wins over MEM; $0 is never forwarded. A
// producer three stages ahead is already in the register file because
// the file writes before it reads, so no WB-stage path is needed.
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] regw_addr_exe,
    input  logic       wb_wen_exe,
    input  logic       mem_ren_exe,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    output fwd_sel_t   sel
);

    // Priority compare: EXE producer first, then MEM producer.
    always_comb begin
        sel = FWD_RF;
        if (src != 5'd0 && wb_wen_exe && regw_addr_exe == src) begin
            sel = mem_ren_exe ? FWD_MEMDIN : FWD_ALU;
        end else if (src != 5'd0 && wb_wen_mem && regw_addr_mem == src) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stall/flush sequencing for branches,
// data-memory waits and debug halt/single-step, operand forwarding
// selects, and cycle/stall/flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);

    state_t                  state_reg, state_next;
    logic                    mem_busy;
    logic                    run_like;
    logic [NUM_STAGES-1:0]   en_vec;   // {if, id, exe, mem, wb}
    logic [NUM_STAGES-1:0]   rst_vec;  // {if, id, exe, mem, wb}
    logic                    cyc_inc, stall_inc, flush_inc;
    logic [CNT_W-1:0]        cnt_cycle_reg, cnt_stall_reg, cnt_flush_reg;
    logic [4:0]              fwd_src [2];
    fwd_sel_t                fwd_sel [2];

    // A pending MEM access that has not been acknowledged this cycle.
    assign mem_busy = (bus.mem_ren_mem | bus.mem_wen_mem) & ~bus.mem_ack;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= INIT;
        else        state_reg <= state_next;
    end

    // Next state and stage controls. An unacknowledged memory access
    // freezes every stage even in RUN/STEP so nothing leaves MEM early.
    always_comb begin
        state_next = state_reg;
        run_like   = 1'b0;
        en_vec     = '0;
        rst_vec    = '0;
        case (state_reg)
            INIT: begin
                rst_vec    = '1;
                state_next = RUN;
            end
            RUN: begin
                run_like = 1'b1;
                if (mem_busy)          state_next = MEM_WAIT;
                else if (bus.debug_en) state_next = HALT;
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    run_like   = 1'b1;
                    state_next = RUN;
                end
            end
            HALT: begin
                if (bus.debug_step)    state_next = STEP;
                else if (!bus.debug_en) state_next = RUN;
            end
            STEP: begin
                run_like   = 1'b1;
                state_next = mem_busy ? MEM_WAIT : HALT;
            end
            default: state_next = INIT;
        endcase

        if (run_like && !mem_busy) begin
            en_vec = '1;
            if (bus.is_branch_id || bus.is_branch_exe) begin
                en_vec[4]  = 1'b0;  // hold fetch until target is known
                rst_vec[1+2] = 1'b1;
            end
            if (bus.is_branch_mem) begin
                en_vec[4]  = 1'b1;  // PC loads the branch target
                rst_vec[1+2] = 1'b1;
            end
        end
    end

    assign {bus.if_en,  bus.id_en,  bus.exe_en,  bus.mem_en,  bus.wb_en}  = en_vec;
    assign {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst} = rst_vec;
    assign bus.halted = (state_reg == HALT);

    // Counter qualifiers: nothing counts in INIT or HALT. Stalls are
    // unacknowledged wait cycles plus RUN-style cycles with fetch held
    // (excluding single-step cycles).
    assign cyc_inc   = (state_reg != INIT) && (state_reg != HALT);
    assign stall_inc = (state_reg == MEM_WAIT && !bus.mem_ack) ||
                       (run_like && state_reg != STEP && !en_vec[4]);
    assign flush_inc = rst_vec[3] && (state_reg != INIT);

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_cycle_reg <= '0;
            cnt_stall_reg <= '0;
            cnt_flush_reg <= '0;
        end else begin
            if (cyc_inc)   cnt_cycle_reg <= cnt_cycle_reg + CNT_W'(1);
            if (stall_inc) cnt_stall_reg <= cnt_stall_reg + CNT_W'(1);
            if (flush_inc) cnt_flush_reg <= cnt_flush_reg + CNT_W'(1);
        end
    end

    assign bus.cnt_cycle = cnt_cycle_reg;
    assign bus.cnt_stall = cnt_stall_reg;
    assign bus.cnt_flush = cnt_flush_reg;

    // One forwarding unit per ID source operand (0: rs, 1: rt).
    assign fwd_src[0] = bus.addr_rs_id;
    assign fwd_src[1] = bus.addr_rt_id;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .src           (fwd_src[gi]),
                .regw_addr_exe (bus.regw_addr_exe),
                .wb_wen_exe    (bus.wb_wen_exe),
                .mem_ren_exe   (bus.mem_ren_exe),
                .regw_addr_mem (bus.regw_addr_mem),
                .wb_wen_mem    (bus.wb_wen_mem),
                .sel           (fwd_sel[gi])
            );
        end
    endgenerate

    assign bus.exe_fwd_a_ctrl = fwd_sel[0];
    assign bus.exe_fwd_b_ctrl = fwd_sel[1];

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of each performance counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port debug_en, input, 1 bit: level signal requesting that the pipeline halt.
REQ-005 The block SHALL have port debug_step, input, 1 bit: one-cycle pulse requesting a single-step advance while halted.
REQ-006 The block SHALL have ports is_branch_id, is_branch_exe, is_branch_mem, inputs, 1 bit each: a jump/branch occupies that stage.
REQ-007 The block SHALL have ports addr_rs_id and addr_rt_id, inputs, 5 bits each: source register numbers of the instruction in ID.
REQ-008 The block SHALL have ports regw_addr_exe, wb_wen_exe and mem_ren_exe, inputs, 5/1/1 bits: the EXE-stage producer.
REQ-009 The block SHALL have ports regw_addr_mem, wb_wen_mem, mem_ren_mem and mem_wen_mem, inputs, 5/1/1/1 bits: the MEM-stage producer and its memory access.
REQ-010 The block SHALL have port mem_ack, input, 1 bit: data memory has completed the current MEM access.
REQ-011 The block SHALL have ports exe_fwd_a_ctrl and exe_fwd_b_ctrl, outputs, 2 bits each: operand forwarding selects for the instruction in ID.
REQ-012 The block SHALL have ports if_rst, id_rst, exe_rst, mem_rst and wb_rst, outputs, 1 bit each: synchronous stage flush, active-high.
REQ-013 The block SHALL have ports if_en, id_en, exe_en, mem_en and wb_en, outputs, 1 bit each: stage advance enables.
REQ-014 The block SHALL have ports cnt_cycle, cnt_stall and cnt_flush, outputs, CNT_W bits each: performance counters.
REQ-015 The block SHALL have port halted, output, 1 bit: high while the FSM is in HALT.

Function
REQ-016 The FSM SHALL have states INIT, RUN, MEM_WAIT, HALT and STEP.
REQ-017 INIT SHALL last exactly one cycle after rst_n rises, assert all *_rst, deassert all *_en, and go to RUN.
REQ-018 RUN SHALL go to MEM_WAIT when (mem_ren_mem|mem_wen_mem)&!mem_ack, else to HALT when debug_en, else stay in RUN.
REQ-019 MEM_WAIT SHALL drive all *_en=0 and all *_rst=0, freezing every stage with WB held rather than bubbled.
REQ-020 MEM_WAIT SHALL return to RUN in the cycle mem_ack is sampled high, with that cycle's outputs already equal to RUN outputs.
REQ-021 HALT SHALL drive all *_en=0, go to STEP on debug_step, and go to RUN when debug_en is low.
REQ-022 STEP SHALL apply RUN outputs for exactly one cycle, then return to HALT, or to MEM_WAIT if the REQ-018 memory condition holds.
REQ-023 A memory wait SHALL take priority over debug_en; debug_en is honoured only once the wait ends.
REQ-024 In RUN and STEP, all *_en SHALL be 1 by default.
REQ-025 In RUN and STEP, while is_branch_id|is_branch_exe: if_en=0 and id_rst=1.
REQ-026 In RUN and STEP, while is_branch_mem: if_en=1 (PC takes the target) and id_rst=1.
REQ-027 The ISA has no delay slot: id_rst SHALL be asserted from a branch's ID cycle through its MEM cycle, giving 3 bubbles per branch.
REQ-028 In RUN and STEP, exe_rst, mem_rst, wb_rst and if_rst SHALL be 0.
REQ-029 Forwarding SHALL be evaluated independently for rs→fwd_a and rt→fwd_b.
REQ-030 Forwarding select 11 (alu_out_mem) SHALL apply when wb_wen_exe & regw_addr_exe==src & src!=0 & !mem_ren_exe.
REQ-031 Forwarding select 10 (mem_din) SHALL apply on that same match when mem_ren_exe=1.
REQ-032 Forwarding select 01 (regw_data_wb) SHALL apply when wb_wen_mem & regw_addr_mem==src & src!=0.
REQ-033 Forwarding select 00 (register file) SHALL apply otherwise.
REQ-034 An EXE match SHALL beat a MEM match; register 0 is never forwarded.
REQ-035 A distance-3 dependency SHALL use select 00, because the register file writes before it reads in the same cycle.
REQ-036 The forwarding selects SHALL be purely combinational from inputs.
REQ-037 cnt_cycle SHALL increment every cycle outside INIT.
REQ-038 cnt_stall SHALL increment in every MEM_WAIT cycle and in every cycle in which if_en=0 in RUN.
REQ-039 cnt_flush SHALL increment in every cycle with id_rst=1 outside INIT.
REQ-040 All counters SHALL wrap modulo 2^CNT_W and SHALL not count in HALT.

Reset
REQ-041 While rst_n=0: state=INIT, all *_rst=1, all *_en=0, counters=0, halted=0.
REQ-042 Assertion of rst_n mid-operation (including during MEM_WAIT or STEP) SHALL take effect immediately and asynchronously.

Structure
REQ-043 A shared package SHALL hold the FSM state enum and the forwarding-select encodings FWD_RF=00, FWD_WB=01, FWD_MEMDIN=10, FWD_ALU=11.
REQ-044 Forwarding logic SHALL be one sub-module, fwd_unit, instantiated once per operand.

Verification
REQ-045 Release rst_n → one INIT cycle with all rst=1, then RUN with all en=1, counters counting from 0.
REQ-046 add $3 in EXE and sub using $3 as rs in ID → fwd_a=11; the same case with lw $3 in EXE → fwd_a=10; $3 in both EXE and MEM → 11; rs=$0 matched → 00.
REQ-047 beq enters ID at cycle t → if_en=0 at t and t+1, if_en=1 at t+2, id_rst=1 for t..t+2, cnt_flush+=3.
REQ-048 lw in MEM with mem_ack held low for 4 cycles → all en=0 for 4 cycles, WB held, cnt_stall+=4, pipeline resumes on ack.
REQ-049 Assert debug_en, then pulse debug_step twice → halted=1, exactly two single-cycle advances, cnt_cycle frozen in HALT.
REQ-050 Drop rst_n while in MEM_WAIT → outputs go to their reset values without a clock edge.
